uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, IDLE/START/DATA/STOP FSM and a show-ahead
// receive FIFO with sticky framing-error and overrun flags.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       IO_CLK,
   input  logic       IO_RST,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   input  logic       err_clr_i,
   output logic       busy_o
);

   // Handshake: a byte leaves the FIFO on any rising edge where rx_valid_o && rx_ready_i;
   // rx_data_o is stable while rx_valid_o is high and meaningless while it is low.

   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0]     BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0]     HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]     DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [15:0]   cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   logic          rx_meta;
   logic          rx_s;
   logic          rx_prev;
   logic          meta_live;
   logic          sync_live;

   logic          stop_hit;
   logic          push;
   logic          ferr_set;
   logic          pop;
   logic          full;
   logic          wr_en;
   logic          ovr_set;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [7:0]    mem [FIFO_DEPTH];

   // rx_prev only tracks samples that really came from the line, so the reset value
   // of the synchronizer can never fake a falling edge against a line that is low.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_prev   <= 1'b0;
         meta_live <= 1'b0;
         sync_live <= 1'b0;
      end else begin
         rx_meta   <= rx_i;
         rx_s      <= rx_meta;
         meta_live <= 1'b1;
         sync_live <= meta_live;
         rx_prev   <= sync_live ? rx_s : 1'b0;
      end
   end

   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         busy_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  state  <= START;
                  cnt    <= '0;
                  busy_o <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  shift[bit_idx] <= rx_s;
                  cnt            <= '0;
                  if (bit_idx == 3'd7) state <= STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_o <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   assign stop_hit = (state == STOP) && (cnt == BIT_LAST);
   assign push     = stop_hit && rx_s;
   assign ferr_set = stop_hit && !rx_s;
   assign pop      = (count != '0) && rx_ready_i;
   assign full     = (count == DEPTH_C);
   assign wr_en    = push && (!full || pop);
   assign ovr_set  = push && full && !pop;

   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge IO_CLK) begin
      if (wr_en) mem[wr_ptr] <= shift;
   end

   // A set event in the same cycle as err_clr_i keeps the flag high.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= ferr_set | (frame_err_o & ~err_clr_i);
         overrun_o   <= ovr_set  | (overrun_o   & ~err_clr_i);
      end
   end

   assign rx_data_o  = mem[rd_ptr];
   assign rx_valid_o = (count != '0);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       IO_CLK = 1'b0;
   logic       IO_RST = 1'b1;
   logic       rx_i = 1'b1;
   logic       rx_ready_i = 1'b0;
   logic       err_clr_i = 1'b0;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   int         checks = 0;
   int         failures = 0;
   int         valid_cycles = 0;
   logic       busy_seen = 1'b0;
   logic [7:0] last_data = 8'h00;

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .IO_CLK      (IO_CLK),
      .IO_RST      (IO_RST),
      .rx_i        (rx_i),
      .rx_data_o   (rx_data_o),
      .rx_valid_o  (rx_valid_o),
      .rx_ready_i  (rx_ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .err_clr_i   (err_clr_i),
      .busy_o      (busy_o)
   );

   always #5 IO_CLK = ~IO_CLK;

   always @(negedge IO_CLK) begin
      if (rx_valid_o) begin
         valid_cycles = valid_cycles + 1;
         last_data    = rx_data_o;
      end
      if (busy_o) busy_seen = 1'b1;
   end

   // Drivers: every task starts and ends 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_i = 1'b0;
      repeat (CPB) @(posedge IO_CLK);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(posedge IO_CLK);
         #1;
      end
      rx_i = stop_bit;
      repeat (CPB) @(posedge IO_CLK);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(posedge IO_CLK);
      #1;
   endtask

   task automatic realign();
      @(posedge IO_CLK);
      #1;
   endtask

   task automatic pulse_ready();
      rx_ready_i = 1'b1;
      @(posedge IO_CLK);
      #1;
      rx_ready_i = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr_i = 1'b1;
      @(posedge IO_CLK);
      #1;
      err_clr_i = 1'b0;
   endtask

   task automatic test_reset();
      IO_RST = 1'b1;
      repeat (3) @(posedge IO_CLK);
      #1;
      @(negedge IO_CLK);
      checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
      checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", overrun_o); end
      realign();
      IO_RST = 1'b0;
      idle(5);
   endtask

   task automatic test_single_a5();
      rx_ready_i   = 1'b1;
      valid_cycles = 0;
      send_byte(8'hA5, 1'b1);
      idle(20);
      @(negedge IO_CLK);
      checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL a5_valid_cycles got=%0d exp=1", valid_cycles); end
      checks++; if (last_data !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", last_data); end
      checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL a5_ferr got=%b exp=0", frame_err_o); end
      checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL a5_ovr got=%b exp=0", overrun_o); end
      rx_ready_i = 1'b0;
      realign();
   endtask

   task automatic test_back_to_back();
      rx_ready_i = 1'b0;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(5);
      @(negedge IO_CLK);
      checks++; if (rx_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rx_valid_o); end
      checks++; if (rx_data_o !== 8'h00) begin failures++; $display("FAIL b2b_head0 got=%h exp=00", rx_data_o); end
      pulse_ready();
      @(negedge IO_CLK);
      checks++; if (rx_data_o !== 8'hFF || rx_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_head1 got=%h/%b exp=ff/1", rx_data_o, rx_valid_o); end
      pulse_ready();
      @(negedge IO_CLK);
      checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", rx_valid_o); end
      realign();
   endtask

   task automatic test_overrun();
      rx_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
      idle(2);
      @(negedge IO_CLK);
      checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun_o); end
      realign();
      send_byte(8'h05, 1'b1);
      idle(5);
      @(negedge IO_CLK);
      checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun_o); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'(i)) begin failures++; $display("FAIL ovr_contents got=%h/%b exp=%h/1", rx_data_o, rx_valid_o, 8'(i)); end
         pulse_ready();
         @(negedge IO_CLK);
      end
      checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL ovr_empty got=%b exp=0", rx_valid_o); end
      realign();
      pulse_clr();
      @(negedge IO_CLK);
      checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun_o); end
      realign();
   endtask

   // The 5th stop bit is sampled on the 155th rising edge after its start bit is driven.
   task automatic test_full_push_pop();
      rx_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
      fork
         send_byte(8'h05, 1'b1);
         begin
            repeat (154) @(posedge IO_CLK);
            #1;
            rx_ready_i = 1'b1;
            @(posedge IO_CLK);
            #1;
            rx_ready_i = 1'b0;
         end
      join
      idle(5);
      @(negedge IO_CLK);
      checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL fullpp_ovr got=%b exp=0", overrun_o); end
      for (int i = 2; i <= 5; i++) begin
         checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'(i)) begin failures++; $display("FAIL fullpp_contents got=%h/%b exp=%h/1", rx_data_o, rx_valid_o, 8'(i)); end
         pulse_ready();
         @(negedge IO_CLK);
      end
      checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL fullpp_empty got=%b exp=0", rx_valid_o); end
      realign();
   endtask

   task automatic test_frame_err();
      rx_ready_i   = 1'b0;
      valid_cycles = 0;
      send_byte(8'h3C, 1'b0);
      idle(20);
      @(negedge IO_CLK);
      checks++; if (frame_err_o !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err_o); end
      checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL ferr_no_push got=%0d exp=0", valid_cycles); end
      realign();
      send_byte(8'h3C, 1'b1);
      idle(5);
      @(negedge IO_CLK);
      checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h3C) begin failures++; $display("FAIL ferr_next got=%h/%b exp=3c/1", rx_data_o, rx_valid_o); end
      checks++; if (frame_err_o !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frame_err_o); end
      realign();
      pulse_ready();
      pulse_clr();
      @(negedge IO_CLK);
      checks++; if (frame_err_o !== 1'b0 || rx_valid_o !== 1'b0) begin failures++; $display("FAIL ferr_clr got=%b/%b exp=0/0", frame_err_o, rx_valid_o); end
      realign();
   endtask

   task automatic test_glitch();
      busy_seen    = 1'b0;
      valid_cycles = 0;
      rx_i = 1'b0;
      repeat (4) @(posedge IO_CLK);
      #1;
      idle(30);
      @(negedge IO_CLK);
      checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_entered_start got=%b exp=1", busy_seen); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", busy_o); end
      checks++; if (valid_cycles !== 0 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin failures++; $display("FAIL glitch_quiet got=%0d/%b/%b exp=0/0/0", valid_cycles, frame_err_o, overrun_o); end
      realign();
   endtask

   // Reset lands mid-way through data bit 4 and is held until the frame has gone by.
   task automatic test_reset_mid_frame();
      rx_ready_i   = 1'b0;
      valid_cycles = 0;
      fork
         send_byte(8'h77, 1'b1);
         begin
            repeat (CPB * 5 + 8) @(posedge IO_CLK);
            #1;
            IO_RST = 1'b1;
            @(posedge IO_CLK);
            @(negedge IO_CLK);
            checks++; if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got=%b/%b exp=0/0", busy_o, rx_valid_o); end
            checks++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", frame_err_o, overrun_o); end
         end
      join
      IO_RST = 1'b0;
      idle(20);
      @(negedge IO_CLK);
      checks++; if (valid_cycles !== 0 || busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_no_byte got=%0d/%b exp=0/0", valid_cycles, busy_o); end
      realign();
      send_byte(8'h77, 1'b1);
      idle(5);
      @(negedge IO_CLK);
      checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h77) begin failures++; $display("FAIL rstmid_next got=%h/%b exp=77/1", rx_data_o, rx_valid_o); end
      realign();
      pulse_ready();
   endtask

   task automatic test_reset_line_low();
      rx_i   = 1'b0;
      IO_RST = 1'b1;
      repeat (3) @(posedge IO_CLK);
      #1;
      IO_RST       = 1'b0;
      busy_seen    = 1'b0;
      valid_cycles = 0;
      repeat (40) @(posedge IO_CLK);
      #1;
      idle(10);
      @(negedge IO_CLK);
      checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL low_no_start got=%b exp=0", busy_seen); end
      checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL low_no_push got=%0d exp=0", valid_cycles); end
      realign();
      send_byte(8'h5A, 1'b1);
      idle(5);
      @(negedge IO_CLK);
      checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A) begin failures++; $display("FAIL low_then_frame got=%h/%b exp=5a/1", rx_data_o, rx_valid_o); end
      realign();
      pulse_ready();
   endtask

   initial begin
      test_reset();
      test_single_a5();
      test_back_to_back();
      test_overrun();
      test_full_push_pop();
      test_frame_err();
      test_glitch();
      test_reset_mid_frame();
      test_reset_line_low();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
